// File: rtl/data_memory_writer_pkg.sv
// Shared definitions for the store path: width codes (common with the load
// read unit), SRAM size codes and the store buffer entry layout.
package data_memory_writer_pkg;

    localparam logic [1:0] MEM_WIDTH1 = 2'd0;
    localparam logic [1:0] MEM_WIDTH2 = 2'd1;
    localparam logic [1:0] MEM_WIDTH4 = 2'd2;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } store_entry_t;

endpackage

// File: rtl/data_memory_writer_store_formatter.sv
// Turns a right-aligned store into SRAM form: size code, byte-lane strobes,
// lane-replicated data and an address-error flag.
module data_memory_writer_store_formatter
    import data_memory_writer_pkg::*;
(
    input  logic [1:0]  width,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    output logic [1:0]  size,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic        misaligned
);

    always_comb begin
        // NOTE: every output gets a default first, so no path through the case infers a latch.
        size       = SIZE_WORD;
        wstrb      = 4'b1111;
        wdata      = data;
        misaligned = (addr_lo != 2'b00);
        case (width)
            MEM_WIDTH1: begin
                size       = SIZE_BYTE;
                wstrb      = 4'b0001 << addr_lo;
                wdata      = {4{data[7:0]}};
                misaligned = 1'b0;
            end
            MEM_WIDTH2: begin
                size       = SIZE_HALF;
                wstrb      = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{data[15:0]}};
                misaligned = addr_lo[0];
            end
            default: ;  // word, and any unknown encoding handled as a word
        endcase
    end

endmodule

// File: rtl/data_memory_writer.sv
// In-order store buffer feeding the data_sram write handshake, with an
// outstanding-write limit and a drained flag for load ordering.
module data_memory_writer
    import data_memory_writer_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int MAX_OUT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [1:0]  st_width,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_misaligned,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [31:0] data_sram_addr,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    output logic        drained
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUT);

    store_entry_t     mem_q [DEPTH];
    store_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [OUT_W-1:0] out_q, out_d;

    store_entry_t fmt_entry;
    store_entry_t head;
    logic         fmt_misaligned;
    logic         push;
    logic         pop;
    logic         ack;

    data_memory_writer_store_formatter u_store_formatter (
        .width      (st_width),
        .addr_lo    (st_addr[1:0]),
        .data       (st_data),
        .size       (fmt_entry.size),
        .wstrb      (fmt_entry.wstrb),
        .wdata      (fmt_entry.wdata),
        .misaligned (fmt_misaligned)
    );
    assign fmt_entry.addr = st_addr;

    // Ready and req come only from registered state; addr_ok never feeds st_ready.
    assign st_ready      = (count_q < DEPTH_C);
    assign st_misaligned = st_valid & fmt_misaligned;
    assign push          = st_valid & st_ready & ~fmt_misaligned;

    assign head            = mem_q[rd_ptr_q];
    assign data_sram_req   = (count_q != '0) && (out_q < MAX_OUT_C);
    assign data_sram_wr    = data_sram_req;
    assign data_sram_addr  = head.addr;
    assign data_sram_size  = head.size;
    assign data_sram_wstrb = head.wstrb;
    assign data_sram_wdata = head.wdata;
    assign pop             = data_sram_req & data_sram_addr_ok;
    // A data_ok with nothing in flight (e.g. left over from before a reset) is dropped.
    assign ack             = data_sram_data_ok && (out_q != '0);
    assign drained         = (count_q == '0) && (out_q == '0);

    always_comb begin
        // NOTE: always_comb uses blocking '=' so later lines see earlier updates; flops below use '<='.
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        out_d    = out_q;
        if (push) begin
            mem_d[wr_ptr_q] = fmt_entry;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: ;
        endcase
        case ({pop, ack})
            2'b10:   out_d = out_q + OUT_W'(1);
            2'b01:   out_d = out_q - OUT_W'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            out_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            out_q    <= out_d;
        end
    end

    // NOTE: entry storage is not reset; count_q guards every read, so stale contents are never used.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_data_memory_writer.sv
// Directed bench for data_memory_writer: lane formatting, misalignment,
// full buffer, outstanding limit and asynchronous reset mid-operation.
module tb_data_memory_writer;
    import data_memory_writer_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        st_valid;
    logic        st_ready;
    logic [1:0]  st_width;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_misaligned;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_wdata;
    logic        addr_ok;
    logic        data_ok;
    logic        drained;

    int errors = 0;
    int checks = 0;

    data_memory_writer #(.DEPTH(2), .MAX_OUT(2)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .st_valid          (st_valid),
        .st_ready          (st_ready),
        .st_width          (st_width),
        .st_addr           (st_addr),
        .st_data           (st_data),
        .st_misaligned     (st_misaligned),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (addr_ok),
        .data_sram_data_ok (data_ok),
        .drained           (drained)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1;
        st_width = w;
        st_addr  = a;
        st_data  = d;
    endtask

    task automatic idle();
        st_valid = 1'b0;
    endtask

    initial begin
        resetn   = 1'b0;
        st_valid = 1'b0;
        st_width = MEM_WIDTH4;
        st_addr  = 32'h0;
        st_data  = 32'h0;
        addr_ok  = 1'b0;
        data_ok  = 1'b0;
        #3;
        check("rst_req", data_sram_req, 0);
        check("rst_drained", drained, 1);
        check("rst_ready", st_ready, 1);
        step();
        step();
        resetn = 1'b1;

        // 1: byte store into lane 3
        drive(MEM_WIDTH1, 32'h0000_1003, 32'h0000_00AB);
        #1;
        check("b_misaligned", st_misaligned, 0);
        check("b_no_bypass", data_sram_req, 0);
        step();
        idle();
        #1;
        check("b_req", data_sram_req, 1);
        check("b_wr", data_sram_wr, 1);
        check("b_addr", data_sram_addr, 32'h0000_1003);
        check("b_size", data_sram_size, SIZE_BYTE);
        check("b_wstrb", data_sram_wstrb, 4'b1000);
        check("b_wdata", data_sram_wdata, 32'hABAB_ABAB);
        check("b_drained_busy", drained, 0);
        step();
        check("b_req_hold", data_sram_req, 1);
        check("b_addr_hold", data_sram_addr, 32'h0000_1003);
        addr_ok = 1'b1;
        step();
        addr_ok = 1'b0;
        #1;
        check("b_req_after_issue", data_sram_req, 0);
        check("b_drained_outstanding", drained, 0);
        data_ok = 1'b1;
        step();
        data_ok = 1'b0;
        #1;
        check("b_drained_done", drained, 1);

        // 2: half store upper lanes, then misaligned stores
        drive(MEM_WIDTH2, 32'h0000_2002, 32'h1234_BEEF);
        step();
        idle();
        #1;
        check("h_req", data_sram_req, 1);
        check("h_addr", data_sram_addr, 32'h0000_2002);
        check("h_size", data_sram_size, SIZE_HALF);
        check("h_wstrb", data_sram_wstrb, 4'b1100);
        check("h_wdata", data_sram_wdata, 32'hBEEF_BEEF);
        addr_ok = 1'b1;
        step();
        addr_ok = 1'b0;
        data_ok = 1'b1;
        step();
        data_ok = 1'b0;
        #1;
        check("h_drained", drained, 1);

        drive(MEM_WIDTH2, 32'h0000_2001, 32'h1234_BEEF);
        #1;
        check("mh_misaligned", st_misaligned, 1);
        check("mh_ready", st_ready, 1);
        step();
        idle();
        #1;
        check("mh_no_req", data_sram_req, 0);
        check("mh_drained", drained, 1);
        check("mh_flag_needs_valid", st_misaligned, 0);
        drive(MEM_WIDTH4, 32'h0000_3002, 32'hDEAD_BEEF);
        #1;
        check("mw_misaligned", st_misaligned, 1);
        step();
        idle();
        drive(MEM_WIDTH1, 32'h0000_3001, 32'h0000_0055);
        #1;
        check("mb_aligned", st_misaligned, 0);
        idle();
        step();
        check("mw_no_req", data_sram_req, 0);
        check("mw_drained", drained, 1);

        // 3: full buffer with addr_ok held low, then in-order release
        drive(MEM_WIDTH4, 32'h0000_0100, 32'h1111_1111);
        step();
        drive(MEM_WIDTH4, 32'h0000_0104, 32'h2222_2222);
        #1;
        check("f_ready_one", st_ready, 1);
        step();
        drive(2'b11, 32'h0000_0108, 32'h3333_3333);
        #1;
        check("f_ready_full", st_ready, 0);
        check("f_req", data_sram_req, 1);
        check("f_addr1", data_sram_addr, 32'h0000_0100);
        step();
        check("f_ready_still_full", st_ready, 0);
        check("f_addr1_stable", data_sram_addr, 32'h0000_0100);
        check("f_wdata1_stable", data_sram_wdata, 32'h1111_1111);
        addr_ok = 1'b1;
        #1;
        check("f_no_ready_from_addr_ok", st_ready, 0);
        step();
        check("f_addr2", data_sram_addr, 32'h0000_0104);
        check("f_wdata2", data_sram_wdata, 32'h2222_2222);
        check("f_ready_after_pop", st_ready, 1);
        step();
        idle();
        #1;
        check("f_req_at_limit", data_sram_req, 0);
        data_ok = 1'b1;
        step();
        data_ok = 1'b0;
        #1;
        check("f_req3", data_sram_req, 1);
        check("f_addr3", data_sram_addr, 32'h0000_0108);
        check("f_size3_default_word", data_sram_size, SIZE_WORD);
        check("f_wstrb3", data_sram_wstrb, 4'b1111);
        check("f_wdata3", data_sram_wdata, 32'h3333_3333);
        step();
        addr_ok = 1'b0;
        #1;
        check("f_req_empty", data_sram_req, 0);
        check("f_drained_busy", drained, 0);
        data_ok = 1'b1;
        step();
        step();
        data_ok = 1'b0;
        #1;
        check("f_drained", drained, 1);

        // 4: outstanding limit with addr_ok always high
        addr_ok = 1'b1;
        drive(MEM_WIDTH4, 32'h0000_0200, 32'hA0A0_A0A0);
        step();
        drive(MEM_WIDTH4, 32'h0000_0204, 32'hA1A1_A1A1);
        step();
        drive(MEM_WIDTH4, 32'h0000_0208, 32'hA2A2_A2A2);
        step();
        idle();
        #1;
        check("o_req_drop", data_sram_req, 0);
        check("o_drained_busy", drained, 0);
        step();
        check("o_req_still_low", data_sram_req, 0);
        data_ok = 1'b1;
        step();
        data_ok = 1'b0;
        #1;
        check("o_req_reassert", data_sram_req, 1);
        check("o_addr_w2", data_sram_addr, 32'h0000_0208);
        step();
        check("o_req_limit_again", data_sram_req, 0);
        drive(MEM_WIDTH4, 32'h0000_020C, 32'hA3A3_A3A3);
        step();
        drive(MEM_WIDTH4, 32'h0000_0210, 32'hA4A4_A4A4);
        step();
        idle();
        #1;
        check("o_ready_full", st_ready, 0);
        check("o_req_blocked", data_sram_req, 0);
        data_ok = 1'b1;
        step();
        check("o_req_w3", data_sram_req, 1);
        check("o_addr_w3", data_sram_addr, 32'h0000_020C);
        step();
        data_ok = 1'b0;
        #1;
        check("o_req_after_same_cycle", data_sram_req, 1);
        check("o_addr_w4", data_sram_addr, 32'h0000_0210);
        step();
        check("o_req_final_limit", data_sram_req, 0);
        check("o_drained_busy2", drained, 0);
        addr_ok = 1'b0;
        data_ok = 1'b1;
        step();
        step();
        data_ok = 1'b0;
        #1;
        check("o_drained", drained, 1);

        // 5: asynchronous reset with two buffered and one outstanding
        drive(MEM_WIDTH4, 32'h0000_0300, 32'hC0C0_C0C0);
        step();
        addr_ok = 1'b1;
        drive(MEM_WIDTH4, 32'h0000_0304, 32'hC1C1_C1C1);
        step();
        addr_ok = 1'b0;
        drive(MEM_WIDTH4, 32'h0000_0308, 32'hC2C2_C2C2);
        step();
        idle();
        #1;
        check("r_req_before", data_sram_req, 1);
        check("r_ready_before", st_ready, 0);
        check("r_addr_before", data_sram_addr, 32'h0000_0304);
        #2;
        resetn = 1'b0;
        #1;
        check("r_req_async", data_sram_req, 0);
        check("r_drained_async", drained, 1);
        check("r_ready_async", st_ready, 1);
        step();
        resetn = 1'b1;
        data_ok = 1'b1;
        step();
        data_ok = 1'b0;
        #1;
        check("r_stale_drained", drained, 1);
        check("r_stale_req", data_sram_req, 0);
        drive(MEM_WIDTH4, 32'h0000_040C, 32'h5A5A_5A5A);
        step();
        idle();
        #1;
        check("r_new_req", data_sram_req, 1);
        check("r_new_addr", data_sram_addr, 32'h0000_040C);
        addr_ok = 1'b1;
        step();
        addr_ok = 1'b0;
        #1;
        check("r_new_outstanding", drained, 0);
        data_ok = 1'b1;
        step();
        data_ok = 1'b0;
        #1;
        check("r_new_drained", drained, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
